// File: rtl/spike_pkg.sv
// Shared definitions for the spike time decoder.
//   NUM_CH_DEF / TIME_W_DEF : default channel count and tick width
//   state_t                 : decoder FSM state encoding
//   field_lsb()             : bit offset of channel c's {enable, time} field
//                             inside a frame word
package spike_pkg;

  localparam int unsigned NUM_CH_DEF = 8;
  localparam int unsigned TIME_W_DEF = 3;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  // Each channel field is TIME_W+1 bits: MSB enable, low TIME_W bits spike time.
  function automatic int unsigned field_lsb(input int unsigned ch, input int unsigned time_w);
    return ch * (time_w + 1);
  endfunction

endpackage

// File: rtl/spike_ch_match.sv
// Per-channel spike compare: fires while the decoder runs, the channel is
// enabled and its programmed spike time equals the current tick.
//   run   : decoder is in RUN
//   en    : channel enable bit from the frame register
//   tm    : channel spike time from the frame register
//   tick  : current tick within the period
//   spike : one-cycle spike pulse for this channel
module spike_ch_match #(
  parameter int unsigned TIME_W = 3
) (
  input  logic              run,
  input  logic              en,
  input  logic [TIME_W-1:0] tm,
  input  logic [TIME_W-1:0] tick,
  output logic              spike
);

  assign spike = run & en & (tm == tick);

endmodule

// File: rtl/spike_time_decoder.sv
// Spike time decoder: accepts a frame word holding one {enable, time} field
// per channel and replays it over a period of 2**TIME_W cycles, pulsing each
// enabled channel at its programmed tick.
//   clk, rst_l  : clock, synchronous active-low reset
//   word_in     : frame word (NUM_CH fields of TIME_W+1 bits)
//   word_valid  : word_in valid
//   word_ready  : word accepted this cycle when also valid
//   spike_out   : per-channel spike pulses
//   tick        : tick within the current period (0 when idle)
//   frame_done  : pulse on the last tick of a period
//   busy        : high while replaying a frame
// Optional macro SPIKE_DECODE_STATS_EN adds:
//   frame_count : accepted frames (wraps at 2**16)
//   spike_count : total emitted spikes (wraps at 2**16)
module spike_time_decoder
  import spike_pkg::*;
#(
  parameter  int unsigned NUM_CH = NUM_CH_DEF,
  parameter  int unsigned TIME_W = TIME_W_DEF,
  localparam int unsigned WORD_W = NUM_CH * (TIME_W + 1)
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic [NUM_CH-1:0] spike_out,
  output logic [TIME_W-1:0] tick,
  output logic              frame_done,
  output logic              busy
`ifdef SPIKE_DECODE_STATS_EN
  ,
  output logic [15:0]       frame_count,
  output logic [15:0]       spike_count
`endif
);

  state_t              state_q, state_d;
  logic [TIME_W-1:0]   tick_q, tick_d;
  logic [WORD_W-1:0]   frame_q, frame_d;
  logic                accept;
  logic                tick_max;
  logic                run;

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      frame_q <= frame_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    frame_d    = frame_q;
    word_ready = 1'b0;
    accept     = 1'b0;
    tick_max   = (tick_q == '1);
    case (state_q)
      ST_IDLE: begin
        word_ready = 1'b1;
        accept     = word_valid;
        if (accept) begin
          state_d = ST_RUN;
          tick_d  = '0;
          frame_d = word_in;
        end
      end
      ST_RUN: begin
        word_ready = tick_max;
        accept     = word_valid & tick_max;
        if (tick_max) begin
          tick_d = '0;
          if (accept) begin
            frame_d = word_in;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tick_d  = '0;
      end
    endcase
  end

  assign run        = (state_q == ST_RUN);
  assign busy       = run;
  assign tick       = tick_q;
  assign frame_done = run & tick_max;

  // Spikes decode purely from registered frame/tick, never from word_in.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam int unsigned LSB = field_lsb(c, TIME_W);
    spike_ch_match #(
      .TIME_W(TIME_W)
    ) u_match (
      .run  (run),
      .en   (frame_q[LSB+TIME_W]),
      .tm   (frame_q[LSB +: TIME_W]),
      .tick (tick_q),
      .spike(spike_out[c])
    );
  end

`ifdef SPIKE_DECODE_STATS_EN
  logic [15:0] frame_count_q;
  logic [15:0] spike_count_q;
  logic [15:0] pop;

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      pop = pop + 16'(spike_out[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      frame_count_q <= '0;
      spike_count_q <= '0;
    end else begin
      if (accept) begin
        frame_count_q <= frame_count_q + 16'd1;
      end
      spike_count_q <= spike_count_q + pop;
    end
  end

  assign frame_count = frame_count_q;
  assign spike_count = spike_count_q;
`endif

endmodule

// File: tb/tb_spike_time_decoder.sv
// Directed bench for spike_time_decoder. Cycle k counts from the accept edge
// (cycle 0 is the cycle in which the word is presented and accepted).
module tb_spike_time_decoder;

  logic        clk;
  logic        rst_l;
  logic [31:0] word_in;
  logic        word_valid;
  logic        word_ready;
  logic [7:0]  spike_out;
  logic [2:0]  tick;
  logic        frame_done;
  logic        busy;
`ifdef SPIKE_DECODE_STATS_EN
  logic [15:0] frame_count;
  logic [15:0] spike_count;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  spike_time_decoder #(
    .NUM_CH(8),
    .TIME_W(3)
  ) dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .word_in    (word_in),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .spike_out  (spike_out),
    .tick       (tick),
    .frame_done (frame_done),
    .busy       (busy)
`ifdef SPIKE_DECODE_STATS_EN
    ,
    .frame_count(frame_count),
    .spike_count(spike_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_l      = 1'b0;
    word_valid = 1'b0;
    word_in    = '0;
    cyc();
    cyc();
    rst_l = 1'b1;
  endtask

  // Accept a single frame from IDLE and check the expected spike per cycle.
  task automatic one_frame(input string tag, input logic [31:0] w, input logic [7:0] exp_sp [1:8]);
    word_in    = w;
    word_valid = 1'b1;
    chk({tag, "_ready0"}, 32'(word_ready), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      word_valid = 1'b0;
      chk($sformatf("%s_spike%0d", tag, k), 32'(spike_out), 32'(exp_sp[k]));
      chk($sformatf("%s_tick%0d", tag, k), 32'(tick), 32'(k - 1));
      chk($sformatf("%s_busy%0d", tag, k), 32'(busy), 32'd1);
      chk($sformatf("%s_done%0d", tag, k), 32'(frame_done), 32'(k == 8));
      chk($sformatf("%s_ready%0d", tag, k), 32'(word_ready), 32'(k == 8));
    end
    cyc();
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_tick"}, 32'(tick), 32'd0);
    chk({tag, "_idle_spike"}, 32'(spike_out), 32'd0);
  endtask

  logic [7:0] sp [1:8];

  initial begin
    rst_l      = 1'b0;
    word_valid = 1'b0;
    word_in    = '0;
    cyc();
    do_reset();

    chk("rst_spike", 32'(spike_out), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_ready", 32'(word_ready), 32'd1);

    // Staircase: channel c fires at time c.
    sp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    one_frame("stair", 32'hFEDC_BA98, sp);

    // All enabled at time 0.
    sp = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    one_frame("zero", 32'h8888_8888, sp);

    // All disabled.
    sp = '{default: 8'h00};
    one_frame("dis", 32'h7777_7777, sp);

    // Back-to-back: second word held valid during the first frame must be
    // ignored until the last tick.
    word_in    = 32'h0000_000F;
    word_valid = 1'b1;
    chk("b2b_ready0", 32'(word_ready), 32'd1);
    for (int k = 1; k <= 17; k++) begin
      cyc();
      if (k == 1) word_in = 32'h0000_0008;
      if (k == 9) word_valid = 1'b0;
      chk($sformatf("b2b_spike%0d", k), 32'(spike_out), 32'((k == 8 || k == 9) ? 1 : 0));
      chk($sformatf("b2b_ready%0d", k), 32'(word_ready), 32'((k == 8 || k == 16 || k == 17) ? 1 : 0));
      chk($sformatf("b2b_busy%0d", k), 32'(busy), 32'(k <= 16));
    end
    chk("b2b_tick_end", 32'(tick), 32'd0);

    // Reset at tick 3 of the staircase frame.
    word_in    = 32'hFEDC_BA98;
    word_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      word_valid = 1'b0;
      chk($sformatf("rmid_spike%0d", k), 32'(spike_out), 32'(1 << (k - 1)));
    end
    chk("rmid_tick3", 32'(tick), 32'd3);
    rst_l = 1'b0;
    cyc();
    rst_l = 1'b1;
    chk("rmid_tick_rst", 32'(tick), 32'd0);
    chk("rmid_ready_rst", 32'(word_ready), 32'd1);
    chk("rmid_busy_rst", 32'(busy), 32'd0);
    for (int k = 6; k <= 12; k++) begin
      chk($sformatf("rmid_quiet%0d", k), 32'(spike_out), 32'd0);
      cyc();
    end

`ifdef SPIKE_DECODE_STATS_EN
    do_reset();
    chk("st_fc_rst", 32'(frame_count), 32'd0);
    chk("st_sc_rst", 32'(spike_count), 32'd0);
    sp = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int f = 0; f < 3; f++) begin
      one_frame("st", 32'h8888_8888, sp);
    end
    chk("st_frame_count", 32'(frame_count), 32'd3);
    chk("st_spike_count", 32'(spike_count), 32'd24);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
